// File: rtl/evm_vote_tally_if.sv
// Bundle of the tally unit's control and result signals. The master side
// (voting FSM / host) drives votes and requests; the slave side is the tally.
interface evm_vote_tally_if #(
    parameter int CNT_W = 8
);
    logic             mode;
    logic             vote_valid;
    logic [1:0]       incr_party_vote;
    logic             result_req;
    logic             clear_counts;
    logic             vote_ack;
    logic             result_valid;
    logic [1:0]       result_party;
    logic [CNT_W-1:0] result_count;
    logic [CNT_W-1:0] total_votes;
    logic             winner_valid;
    logic [1:0]       winner;
    logic             tie;
    logic             busy;

    modport master (
        output mode, vote_valid, incr_party_vote, result_req, clear_counts,
        input  vote_ack, result_valid, result_party, result_count,
               total_votes, winner_valid, winner, tie, busy
    );

    modport slave (
        input  mode, vote_valid, incr_party_vote, result_req, clear_counts,
        output vote_ack, result_valid, result_party, result_count,
               total_votes, winner_valid, winner, tie, busy
    );
endinterface

// File: rtl/evm_vote_tally.sv
// Four-party saturating vote tally with a serial result readout followed by
// a winner/tie verdict. Votes are edge-detected on vote_valid so a held
// strobe counts once. All outputs come straight from flops.
module evm_vote_tally #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    evm_vote_tally_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READOUT = 2'd1,
        ST_VERDICT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_nxt_s;
    logic [1:0]       idx_r, idx_nxt_s;
    logic             vv_q_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic [CNT_W-1:0] total_r;

    logic             accept_s, clear_s, start_s;
    logic [CNT_W-1:0] cur_s, lead_cnt_s, lead_cnt_r;
    logic [1:0]       lead_s, lead_r;
    logic             tie_run_s, tie_run_r;

    logic             vote_ack_r, result_valid_r, winner_valid_r, tie_r, busy_r;
    logic [1:0]       result_party_r, winner_r;
    logic [CNT_W-1:0] result_count_r;

    logic             result_valid_d_s, winner_valid_d_s, busy_d_s;
    logic [1:0]       result_party_d_s;
    logic [CNT_W-1:0] result_count_d_s;

    assign accept_s = (state_r == ST_IDLE) && bus.mode && bus.vote_valid && !vv_q_r;
    assign clear_s  = (state_r == ST_IDLE) && !bus.mode && bus.clear_counts;
    assign start_s  = (state_r == ST_IDLE) && !bus.mode && bus.result_req && !bus.clear_counts;

    // State register and readout index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state logic: one READOUT cycle per party, then a single VERDICT.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_READOUT;
                else         state_nxt_s = ST_IDLE;
                idx_nxt_s = 2'd0;
            end
            ST_READOUT: begin
                if (idx_r == 2'd3) begin
                    state_nxt_s = ST_VERDICT;
                    idx_nxt_s   = 2'd0;
                end else begin
                    state_nxt_s = ST_READOUT;
                    idx_nxt_s   = idx_r + 2'd1;
                end
            end
            ST_VERDICT: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 2'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = 2'd0;
            end
        endcase
    end

    // Output decode from the next state so the output flops line up with it.
    always_comb begin
        result_valid_d_s = 1'b0;
        result_party_d_s = 2'd0;
        result_count_d_s = '0;
        winner_valid_d_s = 1'b0;
        busy_d_s         = 1'b0;
        case (state_nxt_s)
            ST_READOUT: begin
                result_valid_d_s = 1'b1;
                result_party_d_s = idx_nxt_s;
                result_count_d_s = cnt_r[idx_nxt_s];
                busy_d_s         = 1'b1;
            end
            ST_VERDICT: begin
                winner_valid_d_s = 1'b1;
                busy_d_s         = 1'b1;
            end
            default: begin
                busy_d_s = 1'b0;
            end
        endcase
    end

    // Running-max update for the party reported in the current READOUT cycle.
    always_comb begin
        cur_s      = cnt_r[idx_r];
        lead_s     = lead_r;
        lead_cnt_s = lead_cnt_r;
        tie_run_s  = tie_run_r;
        if (idx_r == 2'd0) begin
            lead_s     = 2'd0;
            lead_cnt_s = cur_s;
            tie_run_s  = 1'b0;
        end else if (cur_s > lead_cnt_r) begin
            lead_s     = idx_r;
            lead_cnt_s = cur_s;
            tie_run_s  = 1'b0;
        end else if (cur_s == lead_cnt_r) begin
            tie_run_s  = 1'b1;
        end else begin
            tie_run_s  = tie_run_r;
        end
    end

    // Party counters, total, and the vote_valid edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
            total_r <= '0;
            vv_q_r  <= 1'b0;
        end else begin
            vv_q_r <= bus.vote_valid;
            if (clear_s) begin
                for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
                total_r <= '0;
            end else if (accept_s) begin
                if (cnt_r[bus.incr_party_vote] != CNT_MAX)
                    cnt_r[bus.incr_party_vote] <= cnt_r[bus.incr_party_vote] + CNT_ONE;
                if (total_r != CNT_MAX)
                    total_r <= total_r + CNT_ONE;
            end
        end
    end

    // Running leader state and held verdict registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lead_r     <= 2'd0;
            lead_cnt_r <= '0;
            tie_run_r  <= 1'b0;
            winner_r   <= 2'd0;
            tie_r      <= 1'b0;
        end else begin
            if (state_r == ST_READOUT) begin
                lead_r     <= lead_s;
                lead_cnt_r <= lead_cnt_s;
                tie_run_r  <= tie_run_s;
            end
            if (state_nxt_s == ST_VERDICT) begin
                winner_r <= lead_s;
                tie_r    <= tie_run_s;
            end
        end
    end

    // Registered handshake and readout outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            vote_ack_r     <= 1'b0;
            result_valid_r <= 1'b0;
            result_party_r <= 2'd0;
            result_count_r <= '0;
            winner_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            vote_ack_r     <= accept_s;
            result_valid_r <= result_valid_d_s;
            result_party_r <= result_party_d_s;
            result_count_r <= result_count_d_s;
            winner_valid_r <= winner_valid_d_s;
            busy_r         <= busy_d_s;
        end
    end

    assign bus.vote_ack     = vote_ack_r;
    assign bus.result_valid = result_valid_r;
    assign bus.result_party = result_party_r;
    assign bus.result_count = result_count_r;
    assign bus.total_votes  = total_r;
    assign bus.winner_valid = winner_valid_r;
    assign bus.winner       = winner_r;
    assign bus.tie          = tie_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_evm_vote_tally.sv
// Bench for evm_vote_tally at CNT_W=4 so saturation is reachable quickly.
// Directed steps from the test plan, then a randomized phase, all checked
// against a count-array reference model.
module tb_evm_vote_tally;
    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cnt_m [4];
    int   total_m;
    int   win_m;

    evm_vote_tally_if #(.CNT_W(CNT_W)) bus ();

    evm_vote_tally #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        total_m = 0;
    endtask

    // Present one vote strobe held for 'hold' cycles, then drop it for one.
    task automatic vote_pulse(input int p, input logic md, input int hold);
        bus.mode            = md;
        bus.incr_party_vote = 2'(p);
        bus.vote_valid      = 1'b1;
        for (int c = 0; c < hold; c++) begin
            tick();
            if (c == 0 && md) begin
                if (cnt_m[p] < MAXV) cnt_m[p]++;
                if (total_m < MAXV) total_m++;
            end
            chk("vote_ack", {31'd0, bus.vote_ack}, (c == 0 && md) ? 32'd1 : 32'd0);
            chk("total_votes", {28'd0, bus.total_votes}, 32'(total_m));
        end
        bus.vote_valid = 1'b0;
        tick();
        chk("vote_ack_low", {31'd0, bus.vote_ack}, 32'd0);
    endtask

    task automatic do_clear(input logic md);
        bus.mode         = md;
        bus.clear_counts = 1'b1;
        tick();
        bus.clear_counts = 1'b0;
        if (!md) model_clear();
        chk("clear_total", {28'd0, bus.total_votes}, 32'(total_m));
    endtask

    // Full readout with a second request injected while busy.
    task automatic readout();
        int mx, nmax, win;
        mx = -1; nmax = 0; win = 0;
        for (int i = 0; i < 4; i++) if (cnt_m[i] > mx) mx = cnt_m[i];
        for (int i = 3; i >= 0; i--) if (cnt_m[i] == mx) begin nmax++; win = i; end
        bus.mode       = 1'b0;
        bus.result_req = 1'b1;
        tick();
        bus.result_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("result_valid", {31'd0, bus.result_valid}, 32'd1);
            chk("result_party", {30'd0, bus.result_party}, 32'(i));
            chk("result_count", {28'd0, bus.result_count}, 32'(cnt_m[i]));
            chk("busy", {31'd0, bus.busy}, 32'd1);
            bus.result_req = (i == 1);
            tick();
        end
        bus.result_req = 1'b0;
        chk("winner_valid", {31'd0, bus.winner_valid}, 32'd1);
        chk("winner", {30'd0, bus.winner}, 32'(win));
        chk("tie", {31'd0, bus.tie}, (nmax > 1) ? 32'd1 : 32'd0);
        chk("result_valid_verdict", {31'd0, bus.result_valid}, 32'd0);
        win_m = win;
        tick();
        chk("winner_valid_end", {31'd0, bus.winner_valid}, 32'd0);
        chk("busy_end", {31'd0, bus.busy}, 32'd0);
        chk("result_valid_end", {31'd0, bus.result_valid}, 32'd0);
        chk("winner_hold", {30'd0, bus.winner}, 32'(win));
    endtask

    initial begin
        int seq [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        bus.mode = 1'b0; bus.vote_valid = 1'b0; bus.incr_party_vote = 2'd0;
        bus.result_req = 1'b0; bus.clear_counts = 1'b0;
        model_clear();

        // Reset for two cycles and check every output.
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_vote_ack", {31'd0, bus.vote_ack}, 32'd0);
        chk("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("rst_result_party", {30'd0, bus.result_party}, 32'd0);
        chk("rst_result_count", {28'd0, bus.result_count}, 32'd0);
        chk("rst_total", {28'd0, bus.total_votes}, 32'd0);
        chk("rst_winner_valid", {31'd0, bus.winner_valid}, 32'd0);
        chk("rst_winner", {30'd0, bus.winner}, 32'd0);
        chk("rst_tie", {31'd0, bus.tie}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        readout();

        // Vote sequence, held strobe, and ignored result-mode votes.
        for (int i = 0; i < 9; i++) vote_pulse(seq[i], 1'b1, 1);
        vote_pulse(2, 1'b1, 5);
        vote_pulse(1, 1'b0, 1);
        vote_pulse(3, 1'b0, 2);
        vote_pulse(2, 1'b1, 1);
        vote_pulse(2, 1'b1, 1);
        for (int i = 0; i < 3; i++) vote_pulse(3, 1'b1, 1);
        readout();

        // Clear ignored in voting mode, effective in result mode.
        do_clear(1'b1);
        do_clear(1'b0);
        readout();

        // Saturation: 17 votes for party 1.
        for (int i = 0; i < 17; i++) vote_pulse(1, 1'b1, 1);
        readout();

        // Reset during the second result_valid cycle.
        bus.mode = 1'b0;
        bus.result_req = 1'b1;
        tick();
        bus.result_req = 1'b0;
        tick();
        chk("mid_result_party", {30'd0, bus.result_party}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        for (int c = 0; c < 6; c++) begin
            chk("rst_mid_result_valid", {31'd0, bus.result_valid}, 32'd0);
            chk("rst_mid_winner_valid", {31'd0, bus.winner_valid}, 32'd0);
            chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
            tick();
        end
        chk("rst_mid_total", {28'd0, bus.total_votes}, 32'd0);
        readout();

        // Randomized mix of votes, clears and readouts.
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 7)
                vote_pulse(int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                           int'($urandom_range(1, 3)));
            else if (op == 7)
                do_clear(1'($urandom_range(0, 3) == 0));
            else
                readout();
        end
        readout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
